// File: rtl/seq_det_sequencer_if.sv
// Word-request and result handshakes between a command source
// and the detector sequencer.
interface seq_det_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CNT_W-1:0] in_len;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic             out_hit;
  logic [CNT_W-1:0] out_first;

  modport master (
    output in_valid, in_data, in_len, out_ready,
    input  in_ready, out_valid, out_count,
    input  out_hit, out_first
  );

  modport slave (
    input  in_valid, in_data, in_len, out_ready,
    output in_ready, out_valid, out_count,
    output out_hit, out_first
  );
endinterface

// File: rtl/seq_det_sequencer.sv
// Shifts a parallel word MSB-first into a serial Moore detector
// and reports how many bits it hit on and where it first hit.
module seq_det_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1),
  parameter int Y_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  seq_det_sequencer_if.slave  bus,
  output logic                det_clr,
  output logic                x,
  input  logic                y,
  output logic                busy
);

  localparam int SW = CNT_W + 2;

  typedef enum logic [2:0] {
    IDLE, CLEAR, SHIFT, DRAIN, RESULT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] len;
  logic [SW-1:0]    s;

  logic [CNT_W-1:0] len_in;
  logic [CNT_W-1:0] shamt;
  logic [SW-1:0]    bit_idx;
  logic             counted;
  logic             last_shift;
  logic             last_drain;

  always_comb begin
    len_in = bus.in_len;
    if (bus.in_len == '0 || bus.in_len > CNT_W'(WIDTH))
      len_in = CNT_W'(WIDTH);
    shamt      = CNT_W'(WIDTH) - len_in;
    bit_idx    = s - SW'(Y_LAT);
    counted    = (s >= SW'(Y_LAT)) && y;
    last_shift = (s == SW'(len) - SW'(1));
    last_drain = (s == SW'(len) + SW'(Y_LAT) - SW'(1));
  end

  assign bus.in_ready = (state == IDLE);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      sreg          <= '0;
      len           <= '0;
      s             <= '0;
      x             <= 1'b0;
      det_clr       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_count <= '0;
      bus.out_hit   <= 1'b0;
      bus.out_first <= '0;
    end else begin
      det_clr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            // left-align so the first bit to send sits at the MSB
            sreg          <= bus.in_data << shamt;
            len           <= len_in;
            s             <= '0;
            bus.out_count <= '0;
            bus.out_hit   <= 1'b0;
            bus.out_first <= '0;
            det_clr       <= 1'b1;
            x             <= 1'b0;
            state         <= CLEAR;
          end
        end
        CLEAR: begin
          x     <= sreg[WIDTH-1];
          sreg  <= sreg << 1;
          state <= SHIFT;
        end
        SHIFT, DRAIN: begin
          s <= s + SW'(1);
          if (counted) begin
            bus.out_count <= bus.out_count + CNT_W'(1);
            if (!bus.out_hit) begin
              bus.out_hit   <= 1'b1;
              bus.out_first <= bit_idx[CNT_W-1:0];
            end
          end
          if (state == SHIFT) begin
            if (last_shift) begin
              x             <= 1'b0;
              state         <= (Y_LAT == 0) ? RESULT : DRAIN;
              bus.out_valid <= (Y_LAT == 0);
            end else begin
              x    <= sreg[WIDTH-1];
              sreg <= sreg << 1;
            end
          end else if (last_drain) begin
            state         <= RESULT;
            bus.out_valid <= 1'b1;
          end
        end
        RESULT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_sequencer.sv
// Directed bench: sequencer driving a two-ones Moore detector model.
module tb_seq_det_sequencer;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;
  localparam int Y_LAT = 1;

  logic clk;
  logic reset;
  logic det_clr;
  logic x;
  logic y;
  logic busy;
  logic [1:0] dst;

  int passed = 0;
  int total  = 0;

  seq_det_sequencer_if #(.WIDTH(WIDTH)) ifc ();

  seq_det_sequencer #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .Y_LAT(Y_LAT)
  ) dut (
    .clk(clk), .reset(reset), .bus(ifc),
    .det_clr(det_clr), .x(x), .y(y), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dst <= 2'd0;
    else if (det_clr) dst <= 2'd0;
    else if (x) dst <= (dst == 2'd2) ? 2'd2 : dst + 2'd1;
    else dst <= 2'd0;
  end
  assign y = (dst == 2'd2);

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] len;
    int cnt;
    int hit;
    int first;
    int elen;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, got, exp);
  endtask

  task automatic run_vec(input vec_t v, input int stall);
    int cyc;
    int el;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] xe;
    el = v.elen;
    cyc = 0;
    while (!ifc.in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("in_ready_idle", ifc.in_ready, 1);
    ifc.in_data  = v.data;
    ifc.in_len   = v.len;
    ifc.in_valid = 1'b1;
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("det_clr_c1", det_clr, 1);
    chk("x_clear", x, 0);
    xs = '0;
    xe = '0;
    for (int k = 0; k < el; k++) begin
      @(negedge clk);
      xs[k] = x;
      xe[k] = v.data[el-1-k];
      if (k == 0) chk("det_clr_c2", det_clr, 0);
    end
    chk("x_pattern", xs, xe);
    @(negedge clk);
    cyc = el + 2;
    chk("x_drain", x, 0);
    while (!ifc.out_valid && cyc < el + 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, el + Y_LAT + 2);
    chk("out_count", ifc.out_count, v.cnt);
    chk("out_hit", ifc.out_hit, v.hit);
    chk("out_first", ifc.out_first, v.first);
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        ifc.in_valid = (i == 1);
        @(negedge clk);
      end
      ifc.in_valid = 1'b0;
      chk("stall_valid", ifc.out_valid, 1);
      chk("stall_count", ifc.out_count, v.cnt);
      chk("stall_hit", ifc.out_hit, v.hit);
      chk("stall_first", ifc.out_first, v.first);
      chk("stall_in_ready", ifc.in_ready, 0);
      chk("stall_busy", busy, 1);
    end
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1 ifc.out_ready = 1'b0;
    @(negedge clk);
    chk("valid_drop", ifc.out_valid, 0);
    chk("ready_back", ifc.in_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    vt[0] = '{16'h001E, 5'd8,  3, 1, 4, 8};
    vt[1] = '{16'hAAAA, 5'd0,  0, 0, 0, 16};
    vt[2] = '{16'hFFFF, 5'd20, 15, 1, 1, 16};
    vt[3] = '{16'h0003, 5'd2,  1, 1, 1, 2};
    vt[4] = '{16'h0001, 5'd1,  0, 0, 0, 1};

    reset         = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.in_len    = '0;
    ifc.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", ifc.in_ready, 1);
    chk("rst_x", x, 0);
    chk("rst_det_clr", det_clr, 0);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_count", ifc.out_count, 0);
    chk("rst_hit", ifc.out_hit, 0);
    chk("rst_first", ifc.out_first, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_vec(vt[i], (i == 0) ? 5 : 0);

    // abandon a full word in its third SHIFT cycle
    ifc.in_data  = 16'hFFFF;
    ifc.in_len   = 5'd16;
    ifc.in_valid = 1'b1;
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("pre_rst_x", x, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_x", x, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", ifc.out_valid, 0);
    chk("mid_rst_ready", ifc.in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_vec(vt[0], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_det_sequencer.md
Name: seq_det_sequencer

Overview:
- Controller that drives a serial Moore pattern-detector FSM (1-bit input x, 1-bit output y).
- Takes a parallel word through a valid/ready handshake, clears the detector, then shifts the word into it one bit per clock, MSB first.
- Samples y over a window aligned to the detector latency and returns the detection count and first-hit position through a second valid/ready handshake.
- Sits between a test or command source and a shared detector instance.

Parameters:
WIDTH, 16, maximum number of bits per word.
CNT_W, $clog2(WIDTH+1), width of the length, count and position fields.
Y_LAT, 1, cycles from x being driven to y reflecting that bit (Moore detector = 1); legal range 0..3.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  word request.
in_ready  output  1  high only in IDLE; transfer when in_valid && in_ready.
in_data  input  WIDTH  word; bits in_data[len-1:0] are sent, index len-1 first.
in_len  input  CNT_W  bits to send; 0 or >WIDTH means WIDTH.
det_clr  output  1  one-cycle synchronous clear pulse to the detector.
x  output  1  serial bit to the detector (registered).
y  input  1  detector output.
out_valid  output  1  result available; held until out_ready.
out_ready  input  1  result consumer ready.
out_count  output  CNT_W  number of counted cycles with y=1.
out_hit  output  1  out_count != 0.
out_first  output  CNT_W  bit index (0 = first bit sent) of the first counted y=1; 0 when no hit.
busy  output  1  state != IDLE.

Behaviour:
- Reset (async, any state): state=IDLE; x=0, det_clr=0, out_valid=0, out_count=0, out_hit=0, out_first=0.
  - in_ready is decoded from state, so it reads 1 while reset is held.
  - Handshakes are ignored while reset=1.
- FSM states: IDLE, CLEAR, SHIFT, DRAIN, RESULT.
- IDLE:
  - On acceptance, latch in_data into the shift register.
  - Latch len = (in_len==0 || in_len>WIDTH) ? WIDTH : in_len.
  - Zero the counters; go to CLEAR.
- CLEAR: det_clr=1 and x=0 for exactly one cycle; go to SHIFT.
- SHIFT:
  - Runs exactly len cycles.
  - Cycle k (0-based) drives x = data[len-1-k].
  - Go to DRAIN when k==len-1, or to RESULT when Y_LAT=0.
- DRAIN: x=0 for Y_LAT cycles, then go to RESULT.
- Sampling:
  - A sample counter s increments on every SHIFT and DRAIN cycle, starting at 0.
  - y is counted only when s >= Y_LAT; that sample belongs to bit index s-Y_LAT.
  - Total sampled cycles = len+Y_LAT; counted samples = len.
  - The first counted y=1 latches out_first = s-Y_LAT.
- RESULT:
  - out_valid=1, with out_count, out_hit and out_first stable.
  - On out_ready, clear out_valid and go to IDLE. in_ready returns the next cycle; there is no same-cycle restart.
  - out_valid with out_ready low stalls indefinitely, with no field changes.
- Latency: with acceptance at edge E0, det_clr is high in cycle 1, SHIFT covers cycles 2..len+1, and out_valid rises at the start of cycle len+Y_LAT+2.
- x is 0 in every state except SHIFT.
- Arithmetic: out_count cannot exceed WIDTH, so no saturation is needed.
- Reset mid-operation abandons the word. No partial result is produced, and the next accepted word is processed normally, including the det_clr pulse.

Test Plan:
All scenarios use WIDTH=16, Y_LAT=1 and a bench detector model that is Moore, outputs y=1 after two consecutive 1s (overlapping), and is cleared by det_clr.
1. Basic: in_len=8, in_data=16'h001E (sent 0,0,0,1,1,1,1,0) -> out_count=3, out_hit=1, out_first=4; x pattern matches the sent order.
2. Full length: in_len=0, in_data=16'hAAAA (16 alternating bits) -> out_count=0, out_hit=0, out_first=0.
3. Clamp: in_len=20, in_data=16'hFFFF -> 16 SHIFT cycles, out_count=15, out_first=1.
4. Latency and clear: word A (in_len=2, data=2'b11) is followed by word B (in_len=1, data=1).
   -> For B, det_clr is high in cycle 1, x=1 in cycle 2, out_valid rises at cycle 4.
   -> B gives out_count=0, proving det_clr removed A's trailing 1.
5. Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid=1 and all fields unchanged; in_ready=0; an in_valid pulse meanwhile is not accepted.
6. Reset mid-SHIFT: assert reset in the 3rd SHIFT cycle of a 16-bit word.
   -> Immediately x=0, busy=0, out_valid=0.
   -> After release, scenario 1 repeated yields identical results.
